// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access-size modes, FSM states, lane widths.
package mem_pkg;

  localparam logic [2:0] TM_WORD   = 3'b000;
  localparam logic [2:0] TM_HALF_U = 3'b001;
  localparam logic [2:0] TM_HALF_S = 3'b010;
  localparam logic [2:0] TM_BYTE_U = 3'b011;
  localparam logic [2:0] TM_BYTE_S = 3'b100;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int BE_W   = LANES;
  localparam int OFF_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  // Undefined modes (101-111) fall back to word accesses.
  function automatic size_t mode_size(input logic [2:0] mode);
    size_t sz;
    case (mode)
      TM_HALF_U, TM_HALF_S: sz = SZ_HALF;
      TM_BYTE_U, TM_BYTE_S: sz = SZ_BYTE;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load aligner: selects the addressed byte/half of a bus word and zero/sign-extends it.
// Also used by the MEM/WB forwarding path.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0]      i_rdata,
  input  logic [OFF_W-1:0] i_offset,
  input  logic [2:0]       i_mode,
  output logic [31:0]      o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_byte = 8'(i_rdata >> {i_offset, 3'b000});
    case (i_mode)
      TM_HALF_U: o_data = {16'h0000, w_half};
      TM_HALF_S: o_data = {{16{w_half[15]}}, w_half};
      TM_BYTE_U: o_data = {24'h000000, w_byte};
      TM_BYTE_S: o_data = {{24{w_byte[7]}}, w_byte};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: req/ack bus with byte lanes, pipeline stall, load extension, misalignment faults.
// Optional busy-timeout abort is compiled in with MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [2:0]        trunk_mode_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       load_data_out,
  output logic              mem_done,
  output logic              misaligned,
  output logic              mem_timeout
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_load;
  logic              r_we;
  logic [2:0]        r_mode;
  logic              r_misaligned;
  logic              r_timeout;

  logic              w_access;
  logic              w_misal;
  size_t             w_size;
  logic [BE_W-1:0]   w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ext;
  logic              w_capture;
  logic              w_fault;
  logic              w_timeout;

  assign w_access = MemRead_in | MemWrite_in;
  assign w_size   = mode_size(trunk_mode_in);
  assign w_misal  = ((w_size == SZ_HALF) && addr_in[0]) ||
                    ((w_size == SZ_WORD) && (addr_in[1:0] != 2'b00));

  // Store data is replicated across lanes so the byte enables alone select the target bytes.
  always_comb begin
    case (w_size)
      SZ_BYTE: begin
        w_be    = BE_W'(1) << addr_in[1:0];
        w_wdata = {4{store_data_in[7:0]}};
      end
      SZ_HALF: begin
        w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
      end
    endcase
  end

  load_extend u_load_extend (
    .i_rdata  (mem_rdata),
    .i_offset (r_addr[1:0]),
    .i_mode   (r_mode),
    .o_data   (w_ext)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_cnt <= '0;
    end else if ((r_state == ST_BUSY) && !mem_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires in the BUSY cycle whose missing ack brings the count to TIMEOUT_CYCLES; a same-cycle ack wins.
  assign w_timeout = (r_state == ST_BUSY) && !mem_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Stall stays high through the ack cycle so the access is still presented during DONE.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    w_capture = 1'b0;
    w_fault   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          stall = 1'b1;
          if (w_misal) begin
            w_fault = 1'b1;
            w_next  = ST_DONE;
          end else begin
            w_capture = 1'b1;
            w_next    = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (mem_ack || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_load       <= '0;
      r_we         <= 1'b0;
      r_mode       <= TM_WORD;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_misaligned <= w_fault;
      r_timeout    <= w_timeout;
      if (w_capture) begin
        r_addr  <= addr_in;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= MemWrite_in;
        r_mode  <= trunk_mode_in;
      end
      if ((r_state == ST_BUSY) && mem_ack && !r_we) begin
        r_load <= w_ext;
      end else if (w_timeout) begin
        r_load <= '0;
      end
    end
  end

  assign mem_req       = (r_state == ST_BUSY);
  assign mem_we        = r_we & mem_req;
  assign mem_addr      = r_addr[ADDR_W-1:2];
  assign mem_be        = r_be;
  assign mem_wdata     = r_wdata;
  assign load_data_out = r_load;
  assign mem_done      = (r_state == ST_DONE);
  assign misaligned    = r_misaligned;
  assign mem_timeout   = r_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected bus/completion records, a monitor checks them.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [2:0]  trunk_mode_in;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] load_data_out;
  logic        mem_done;
  logic        misaligned;
  logic        mem_timeout;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .trunk_mode_in (trunk_mode_in),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .load_data_out (load_data_out),
    .mem_done      (mem_done),
    .misaligned    (misaligned),
    .mem_timeout   (mem_timeout)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] load;
    logic        mis;
    logic        tmo;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  bus_t  mon_b;
  done_t mon_d;
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  prev_req = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus_t b;
    b.we = we; b.addr = a[31:2]; b.be = be; b.wdata = wd;
    exp_bus.push_back(b);
  endtask

  task automatic push_done(input logic [31:0] ld, input logic mis, input logic tmo);
    done_t d;
    d.load = ld; d.mis = mis; d.tmo = tmo;
    exp_done.push_back(d);
  endtask

  // Monitor: checks bus fields on each new request and the result on each completion pulse.
  always @(negedge clock) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (exp_bus.size() == 0) begin
          check("unexpected_req", 32'(mem_req), 32'(0));
        end else begin
          mon_b = exp_bus.pop_front();
          check("bus_we",    32'(mem_we), 32'(mon_b.we));
          check("bus_addr",  32'(mem_addr), 32'(mon_b.addr));
          check("bus_be",    32'(mem_be), 32'(mon_b.be));
          check("bus_wdata", mem_wdata, mon_b.wdata);
        end
      end
      if (misaligned) check("mis_with_done", 32'(mem_done), 32'(1));
      if (mem_done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 32'(mem_done), 32'(0));
        end else begin
          mon_d = exp_done.pop_front();
          check("done_load",    load_data_out, mon_d.load);
          check("done_mis",     32'(misaligned), 32'(mon_d.mis));
          check("done_timeout", 32'(mem_timeout), 32'(mon_d.tmo));
          check("done_req_low", 32'(mem_req), 32'(0));
        end
      end
      prev_req = mem_req;
    end
  end

  // Presents one access at the start of an IDLE cycle, plays a memory that acks after dly
  // BUSY cycles (garbage rdata outside the ack cycle), and removes the access after DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] m, input int dly,
                            input logic [31:0] rdat, input int exp_stall);
    int st;
    int rq;
    bit seen;
    st = 0; rq = 0; seen = 0;
    MemRead_in = rd; MemWrite_in = wr; addr_in = a; store_data_in = d; trunk_mode_in = m;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      if (stall) st++;
      if (mem_done) begin
        seen = 1;
        MemRead_in = 1'b0; MemWrite_in = 1'b0; mem_ack = 1'b0;
      end else if (mem_req) begin
        rq++;
        mem_ack   = ((rq - 1) == dly);
        mem_rdata = mem_ack ? rdat : 32'hDEADBEEF;
      end
    end
    check("done_within_budget", 32'(seen), 32'(1));
    check("stall_cycles", 32'(st), 32'(exp_stall));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rq;
    reset = 1'b1; addr_in = '0; store_data_in = '0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    trunk_mode_in = 3'b000; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req",     32'(mem_req), 32'(0));
    check("rst_we",      32'(mem_we), 32'(0));
    check("rst_done",    32'(mem_done), 32'(0));
    check("rst_mis",     32'(misaligned), 32'(0));
    check("rst_tmo",     32'(mem_timeout), 32'(0));
    check("rst_addr",    32'(mem_addr), 32'(0));
    check("rst_be",      32'(mem_be), 32'(0));
    check("rst_wdata",   mem_wdata, 32'h0);
    check("rst_load",    load_data_out, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Word load, zero-wait
    push_bus(0, 32'h100, 4'b1111, 32'h0); push_done(32'h8899AABB, 0, 0);
    run_access(1, 0, 32'h100, 32'h0, 3'b000, 0, 32'h8899AABB, 2);
    // Signed / unsigned byte at offset 3
    push_bus(0, 32'h103, 4'b1000, 32'h0); push_done(32'hFFFFFF80, 0, 0);
    run_access(1, 0, 32'h103, 32'h0, 3'b100, 0, 32'h80FF0000, 2);
    push_bus(0, 32'h103, 4'b1000, 32'h0); push_done(32'h00000080, 0, 0);
    run_access(1, 0, 32'h103, 32'h0, 3'b011, 0, 32'h80FF0000, 2);
    // Half store to upper lanes; load result unchanged
    push_bus(1, 32'h202, 4'b1100, 32'hABCDABCD); push_done(32'h00000080, 0, 0);
    run_access(0, 1, 32'h202, 32'h1234ABCD, 3'b001, 0, 32'h0, 2);
    // Misaligned word: no bus request, one stall cycle
    push_done(32'h00000080, 1, 0);
    run_access(1, 0, 32'h101, 32'h0, 3'b000, 0, 32'h0, 1);
    // Signed half at offset 2, two wait states
    push_bus(0, 32'h206, 4'b1100, 32'h0); push_done(32'hFFFF9ABC, 0, 0);
    run_access(1, 0, 32'h206, 32'h0, 3'b010, 2, 32'h9ABC1234, 4);
    // Byte store (sign mode irrelevant), lane 1
    push_bus(1, 32'h301, 4'b0010, 32'h88888888); push_done(32'hFFFF9ABC, 0, 0);
    run_access(0, 1, 32'h301, 32'h55667788, 3'b100, 0, 32'h0, 2);
    // Read and write together is a write; mode 111 acts as word
    push_bus(1, 32'h0, 4'b1111, 32'hCAFEF00D); push_done(32'hFFFF9ABC, 0, 0);
    run_access(1, 1, 32'h0, 32'hCAFEF00D, 3'b111, 0, 32'h0, 2);
    // Misaligned half
    push_done(32'hFFFF9ABC, 1, 0);
    run_access(1, 0, 32'h3, 32'h0, 3'b001, 0, 32'h0, 1);
    // Unsigned byte lane 1, one wait state
    push_bus(0, 32'h1, 4'b0010, 32'h0); push_done(32'h000000A5, 0, 0);
    run_access(1, 0, 32'h1, 32'h0, 3'b011, 1, 32'h0000A500, 3);
    // Top-of-address-space word
    push_bus(0, 32'hFFFFFFFC, 4'b1111, 32'h0); push_done(32'h01234567, 0, 0);
    run_access(1, 0, 32'hFFFFFFFC, 32'h0, 3'b000, 0, 32'h01234567, 2);

    // Reset during the third BUSY cycle of a slow access, then a late ack
    push_bus(0, 32'h10, 4'b1111, 32'h0);
    MemRead_in = 1'b1; addr_in = 32'h10; trunk_mode_in = 3'b000; store_data_in = '0;
    rq = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (mem_req) rq++;
      if (rq == 3) begin
        reset = 1'b1; MemRead_in = 1'b0;
        break;
      end
    end
    check("rst_busy_reached", 32'(rq), 32'(3));
    @(negedge clock);
    check("rst_busy_req",   32'(mem_req), 32'(0));
    check("rst_busy_done",  32'(mem_done), 32'(0));
    check("rst_busy_load",  load_data_out, 32'h0);
    check("rst_busy_stall", 32'(stall), 32'(0));
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("late_ack_done", 32'(mem_done), 32'(0));
      check("late_ack_req",  32'(mem_req), 32'(0));
    end
    mem_ack = 1'b0;
    @(posedge clock); #1;

    push_bus(0, 32'h44, 4'b1111, 32'h0); push_done(32'h5A5A5A5A, 0, 0);
    run_access(1, 0, 32'h44, 32'h0, 3'b000, 0, 32'h5A5A5A5A, 2);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 BUSY cycles with load cleared
    push_bus(0, 32'h40, 4'b1111, 32'h0); push_done(32'h0, 0, 1);
    run_access(1, 0, 32'h40, 32'h0, 3'b000, 1000, 32'h0, 5);
`endif

    repeat (2) @(posedge clock);
    check("bus_queue_empty",  32'(exp_bus.size()), 32'(0));
    check("done_queue_empty", 32'(exp_done.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
